// File: rtl/rr_arbiter_4.sv
// Four-requester round-robin arbiter with a per-grant hold limit.
// The grant is registered; a revoked grant is always followed by one idle cycle.
module rr_arbiter_4 #(
    parameter int HOLD_MAX = 15,
    parameter int CW       = 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_en,
    input  logic [3:0] i_req,
    output logic [3:0] o_gnt,
    output logic [1:0] o_gnt_id,
    output logic       o_busy,
    output logic       o_timeout
);

    localparam logic [CW-1:0] CNT_LAST = CW'(HOLD_MAX - 1);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [3:0]    r_gnt;
    logic [3:0]    w_gnt_nxt;
    logic [1:0]    r_gnt_id;
    logic [1:0]    w_gnt_id_nxt;
    logic [1:0]    r_last_id;
    logic [1:0]    w_last_id_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic          r_timeout;
    logic          w_timeout_nxt;
    logic          w_found;
    logic [1:0]    w_winner;

    // Walks from the lowest-priority slot (last itself) up to last+1, so the
    // final hit is the requester immediately after the one last served.
    function automatic logic [2:0] pick_next(input logic [3:0] req, input logic [1:0] last);
        logic [2:0] res;
        logic [1:0] idx;
        res = 3'b000;
        for (int k = 3; k >= 0; k--) begin
            idx = last + 2'(k + 1);
            if (req[idx]) begin
                res = {1'b1, idx};
            end
        end
        return res;
    endfunction

    always_comb begin
        {w_found, w_winner} = pick_next(i_req, r_last_id);
    end

    always_comb begin
        w_state_nxt   = r_state;
        w_gnt_nxt     = r_gnt;
        w_gnt_id_nxt  = r_gnt_id;
        w_last_id_nxt = r_last_id;
        w_cnt_nxt     = r_cnt;
        w_timeout_nxt = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_gnt_nxt = 4'b0000;
                if (i_en && w_found) begin
                    w_state_nxt  = ST_GRANT;
                    w_gnt_nxt    = 4'b0001 << w_winner;
                    w_gnt_id_nxt = w_winner;
                    w_cnt_nxt    = '0;
                end
            end
            ST_GRANT: begin
                if (!i_en || !i_req[r_gnt_id] || (r_cnt == CNT_LAST)) begin
                    w_state_nxt   = ST_IDLE;
                    w_gnt_nxt     = 4'b0000;
                    w_last_id_nxt = r_gnt_id;
                    w_cnt_nxt     = '0;
                    // Reaching here with en and req still high means the hold limit fired.
                    w_timeout_nxt = i_en && i_req[r_gnt_id];
                end else begin
                    w_cnt_nxt = r_cnt + CW'(1);
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_gnt_nxt   = 4'b0000;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= ST_IDLE;
            r_gnt     <= 4'b0000;
            r_gnt_id  <= 2'b00;
            r_last_id <= 2'b11;
            r_cnt     <= '0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_gnt     <= w_gnt_nxt;
            r_gnt_id  <= w_gnt_id_nxt;
            r_last_id <= w_last_id_nxt;
            r_cnt     <= w_cnt_nxt;
            r_timeout <= w_timeout_nxt;
        end
    end

    assign o_gnt     = r_gnt;
    assign o_gnt_id  = r_gnt_id;
    assign o_busy    = |r_gnt;
    assign o_timeout = r_timeout;

endmodule

// File: tb/tb_rr_arbiter_4.sv
// Bench for rr_arbiter_4: directed scenarios plus biased random traffic,
// every cycle compared against a cycle-level behavioural model.
module tb_rr_arbiter_4;

    localparam int HM = 4;
    localparam int CW = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic [3:0] req = 4'b0000;
    logic [3:0] gnt;
    logic [1:0] gnt_id;
    logic       busy;
    logic       tmo;

    int n_checks = 0;
    int n_err    = 0;

    // Model: m_g = granted requester or -1, m_hold = cycles the grant has been visible.
    int m_g    = -1;
    int m_gid  = 0;
    int m_last = 3;
    int m_hold = 0;
    bit m_to   = 1'b0;

    always #5 clk = ~clk;

    rr_arbiter_4 #(.HOLD_MAX(HM), .CW(CW)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_en      (en),
        .i_req     (req),
        .o_gnt     (gnt),
        .o_gnt_id  (gnt_id),
        .o_busy    (busy),
        .o_timeout (tmo)
    );

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic model_edge();
        if (rst) begin
            m_g = -1; m_gid = 0; m_last = 3; m_hold = 0; m_to = 1'b0;
        end else if (m_g < 0) begin
            m_to = 1'b0;
            if (en) begin
                for (int k = 1; k <= 4; k++) begin
                    if (m_g < 0 && req[(m_last + k) % 4]) begin
                        m_g = (m_last + k) % 4;
                        m_gid = m_g;
                        m_hold = 1;
                    end
                end
            end
        end else if (!en || !req[m_g] || m_hold == HM) begin
            m_to = en && req[m_g] && (m_hold == HM);
            m_last = m_g;
            m_g = -1;
        end else begin
            m_hold++;
            m_to = 1'b0;
        end
    endtask

    task automatic step(input logic r, input logic e, input logic [3:0] q);
        rst = r; en = e; req = q;
        @(posedge clk);
        model_edge();
        #1;
        chk("gnt", gnt, (m_g < 0) ? 4'b0000 : 4'(1 << m_g));
        chk("gnt_id", {2'b00, gnt_id}, 4'(m_gid));
        chk("busy", {3'b000, busy}, {3'b000, (m_g >= 0)});
        chk("timeout", {3'b000, tmo}, {3'b000, m_to});
        chk("onehot0", {3'b000, $onehot0(gnt)}, 4'b0001);
    endtask

    initial begin
        logic [3:0] order[$];
        logic [3:0] prev;
        logic [3:0] rr_exp[5];
        logic [3:0] to_gnt[10];
        logic [9:0] to_pulse;
        logic [3:0] q;
        int         cnt;
        int         tcnt;

        // Reset held with all requesting, then released
        step(1'b1, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        chk("rst_gnt", gnt, 4'b0000);
        chk("rst_busy", {3'b000, busy}, 4'b0000);
        step(1'b0, 1'b1, 4'hF);
        chk("first_gnt", gnt, 4'b0001);
        chk("first_id", {2'b00, gnt_id}, 4'd0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);

        // Single requester for three edges
        cnt = 0; tcnt = 0;
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, (i < 3) ? 4'b0100 : 4'b0000);
            if (gnt == 4'b0100) cnt++;
            if (tmo) tcnt++;
        end
        chk("single_len", 4'(cnt), 4'd3);
        chk("single_tmo", 4'(tcnt), 4'd0);

        // Round-robin: each holder drops req after two grant cycles
        step(1'b1, 1'b1, 4'h0);
        rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        prev = 4'b0000;
        for (int i = 0; i < 16; i++) begin
            q = 4'hF;
            if (m_g >= 0 && m_hold == 2) q[m_g] = 1'b0;
            step(1'b0, 1'b1, q);
            if (gnt != 4'b0000 && prev == 4'b0000) order.push_back(gnt);
            prev = gnt;
        end
        for (int i = 0; i < 5; i++) begin
            chk($sformatf("rr_order_%0d", i), (i < order.size()) ? order[i] : 4'b0000, rr_exp[i]);
        end

        // Hold limit with a lone requester
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        to_gnt = '{4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                   4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000};
        to_pulse = 10'b1000010000;
        for (int i = 0; i < 10; i++) begin
            step(1'b0, 1'b1, 4'b0010);
            chk($sformatf("to_gnt_%0d", i), gnt, to_gnt[i]);
            chk($sformatf("to_pulse_%0d", i), {3'b000, tmo}, {3'b000, to_pulse[i]});
        end

        // Enable drop mid-grant on id 2
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'h0);
        step(1'b0, 1'b1, 4'b0100);
        step(1'b0, 1'b1, 4'b0100);
        chk("en_pre", gnt, 4'b0100);
        step(1'b0, 1'b0, 4'b0100);
        chk("en_drop_gnt", gnt, 4'b0000);
        chk("en_drop_tmo", {3'b000, tmo}, 4'b0000);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b0, 4'hF);
            chk("en_low_gnt", gnt, 4'b0000);
        end
        step(1'b0, 1'b1, 4'hF);
        chk("en_resume", gnt, 4'b1000);

        // Reset mid-grant
        step(1'b0, 1'b1, 4'hF);
        step(1'b1, 1'b1, 4'hF);
        chk("rst_mid_gnt", gnt, 4'b0000);
        chk("rst_mid_id", {2'b00, gnt_id}, 4'd0);
        chk("rst_mid_tmo", {3'b000, tmo}, 4'b0000);
        step(1'b0, 1'b1, 4'hF);
        chk("rst_after", gnt, 4'b0001);

        // Random traffic with sticky request lines
        q = 4'h0;
        for (int i = 0; i < 600; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 5) == 0) q[b] = ~q[b];
            end
            step(($urandom_range(0, 59) == 0), ($urandom_range(0, 9) != 0), q);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/rr_arbiter_4.md
Name: rr_arbiter_4

Overview:
- Four-requester round-robin arbiter that shares one downstream resource.
- Produces a one-hot grant plus a 2-bit grant index.
- The 2-bit index drives the select inputs of the team's 2-to-4 decoder. `busy` drives that decoder's enable.
- Enforces a maximum hold time per grant, so no single requester can monopolise the resource.

Parameters:
- HOLD_MAX, 15, maximum consecutive cycles one grant may be held before forced revocation; range 1..2^CW-1.
- CW, 4, width of the hold counter in bits.

Ports:
- clk  input  1  system clock, all logic on rising edge
- rst  input  1  synchronous, active-high reset
- en  input  1  arbiter enable; when low, no new grants and any active grant is revoked
- req  input  4  request lines, req[i] from requester i; level-sensitive, held high while using the resource
- gnt  output  4  one-hot grant, registered; all zeros when no grant
- gnt_id  output  2  index of the granted requester; holds its last value when idle
- busy  output  1  high exactly when gnt is non-zero
- timeout  output  1  single-cycle pulse when a grant is revoked by the HOLD_MAX limit

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high on rst.
- Reset, sampled at a rising edge of clk, forces:
  - gnt=0000, gnt_id=00, busy=0, timeout=0
  - state=IDLE, hold counter=0
  - internal last_id=11, so req[0] has top priority after reset.
- rst overrides everything, including mid-grant: the grant drops at that edge with no timeout pulse.
- FSM states: IDLE, GRANT.
- IDLE:
  - If en=1 and req!=0, select the first asserted req scanning last_id+1, last_id+2, last_id+3, last_id (mod 4).
  - At the edge, load gnt/gnt_id with the winner, set busy=1, clear the counter and enter GRANT.
  - Latency: req sampled high at edge N gives gnt high after edge N, i.e. visible in cycle N+1.
  - Otherwise stay in IDLE with gnt=0000.
- GRANT, evaluated each edge in this priority order:
  1. en=0: revoke, gnt=0000, busy=0, go to IDLE; last_id=gnt_id; no timeout pulse.
  2. req[gnt_id]=0: release. Revoke and go to IDLE; last_id=gnt_id.
  3. Counter = HOLD_MAX-1: forced revoke. gnt=0000, timeout=1 for exactly one cycle, go to IDLE; last_id=gnt_id.
  4. Else: counter increments and the grant is held.
- Grant cycles:
  - A grant lasts at most HOLD_MAX cycles of gnt high.
  - After any revocation there is exactly one IDLE cycle with gnt=0000 before the next grant. This gap is the decoder-select settling cycle and is mandatory.
- Other requesters' req changes have no effect during GRANT.
- The requester just served goes lowest priority.
  - With all four requesting continuously, grants go 0,1,2,3,0,...
  - A lone requester is re-granted after the one-cycle gap.
- Invariants:
  - gnt is always one-hot or zero; never more than one bit set.
  - busy == |gnt.
  - When gnt!=0, gnt == 1<<gnt_id.
- Counter width: CW bits, no wrap possible because revocation occurs at HOLD_MAX-1. HOLD_MAX=1 grants for exactly one cycle.
- timeout is never asserted in IDLE except in the single cycle following a forced revoke.

Test Plan:
- Reset then idle: hold rst=1 for 2 cycles with req=1111 -> gnt=0000, busy=0, timeout=0. Release rst with en=1, req=1111 -> next cycle gnt=0001, gnt_id=00.
- Single requester: req=0100, held 3 cycles then dropped -> gnt=0100 for 3 cycles, then 0000 the cycle after req drops, busy follows; no timeout.
- Round-robin fairness: req=1111 constant, each requester drops req for one cycle after 2 cycles of grant -> grant order 0001,0010,0100,1000,0001 with one zero cycle between each.
- Timeout: HOLD_MAX=4, req=0010 held 10 cycles -> gnt=0010 for exactly 4 cycles, timeout=1 in the revoke cycle only, 1 idle cycle, re-grant 0010.
- Enable drop: grant active on id 2, en=0 mid-grant -> gnt=0000 at next edge, no timeout. req=1111 held with en=0 -> no grant. en=1 -> grant goes to id 3.
- Reset mid-grant: gnt=1000 active, rst=1 one cycle -> gnt=0000, gnt_id=00. With req=1111 and en=1 after reset -> gnt=0001.
